// File: rtl/master_out_port.sv
// Serialises a latched address/data request onto two LSB-first serial lines after a
// master_valid/slave_ready handshake; reports completion with done or abort with timeout_err.
module master_out_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] address_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  slave_ready,
  output logic                  master_valid,
  output logic                  tx_address,
  output logic                  tx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);

  localparam int CW = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH + 1) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(ADDR_WIDTH - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TW-1:0] TMO_SAT  = TW'(TIMEOUT);
  localparam bit            TMO_ON   = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_sr;
  logic [DATA_WIDTH-1:0] data_sr;
  logic [CW-1:0]         bit_cnt;
  logic [TW-1:0]         tmo_cnt;
  logic                  tmo_err_q;
  logic                  tmo_hit;
  logic                  last_bit;

  // The REQ cycle that would complete TIMEOUT waiting cycles; ready in that cycle still wins.
  assign tmo_hit     = TMO_ON && (tmo_cnt == TMO_LAST);
  assign last_bit    = (bit_cnt == LAST_BIT);
  assign timeout_err = tmo_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    master_valid = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    tx_address   = 1'b0;
    tx_data      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = REQ;
      end
      REQ: begin
        master_valid = 1'b1;
        busy         = 1'b1;
        if (slave_ready) begin
          state_nxt = SHIFT;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        busy       = 1'b1;
        tx_address = addr_sr[0];
        tx_data    = data_sr[0];
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_sr   <= '0;
      data_sr   <= '0;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_err_q <= (state == REQ) && !slave_ready && tmo_hit;
      case (state)
        IDLE: begin
          if (start) begin
            addr_sr <= address_in;
            // Reads shift out zeros on the data line, so the data is dropped at latch time.
            data_sr <= write_en ? data_in : '0;
            tmo_cnt <= '0;
            bit_cnt <= '0;
          end
        end
        REQ: begin
          if (tmo_cnt != TMO_SAT) tmo_cnt <= tmo_cnt + 1'b1;
          if (slave_ready) begin
            bit_cnt <= '0;
          end else if (tmo_hit) begin
            addr_sr <= '0;
            data_sr <= '0;
          end
        end
        SHIFT: begin
          addr_sr <= addr_sr >> 1;
          data_sr <= data_sr >> 1;
          bit_cnt <= bit_cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_master_out_port.sv
// Randomised bench for master_out_port against a transaction-level expected-trace model.
module tb_master_out_port;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          write_en;
  logic [AW-1:0] address_in;
  logic [DW-1:0] data_in;
  logic          slave_ready;
  logic          master_valid, tx_address, tx_data, busy, done, timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  master_out_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .write_en(write_en),
    .address_in(address_in), .data_in(data_in), .slave_ready(slave_ready),
    .master_valid(master_valid), .tx_address(tx_address), .tx_data(tx_data),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (mv,ta,td,busy,done,terr)", tag, obs[5:0], exp[5:0]);
    end
  endtask

  function automatic logic [31:0] outs();
    return {26'd0, master_valid, tx_address, tx_data, busy, done, timeout_err};
  endfunction

  // Expected outputs k cycles after the start edge, for a slave that holds
  // ready low for d request cycles (d >= TO means it never answers in time).
  function automatic logic [31:0] exp_outs(int k, logic [AW-1:0] a, logic [DW-1:0] dt,
                                           bit wr, int d);
    bit mv, ta, td, bz, dn, te;
    int i;
    mv = 0; ta = 0; td = 0; bz = 0; dn = 0; te = 0;
    if (d < TO) begin
      if (k <= d) begin
        mv = 1; bz = 1;
      end else if (k <= d + AW) begin
        i  = k - d - 1;
        bz = 1;
        ta = a[i];
        td = (wr && i < DW) ? dt[i] : 1'b0;
      end else if (k == d + AW + 1) begin
        bz = 1; dn = 1;
      end
    end else begin
      if (k < TO) begin
        mv = 1; bz = 1;
      end else if (k == TO) begin
        te = 1;
      end
    end
    return {26'd0, mv, ta, td, bz, dn, te};
  endfunction

  task automatic idle_cycles(input int n, input string name);
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      start       = 1'b0;
      slave_ready = 1'($urandom % 2);
      address_in  = AW'($urandom);
      data_in     = DW'($urandom);
      write_en    = 1'($urandom % 2);
      @(negedge clk);
      check($sformatf("%s idle%0d", name, j), outs(), 32'd0);
    end
  endtask

  // Entered after the negedge of an idle cycle; returns after the negedge of the
  // first idle cycle following the transfer, so a caller may start back-to-back.
  task automatic run_txn(input string name, input logic [AW-1:0] a, input logic [DW-1:0] dt,
                         input bit wr, input int d, input int abort_k);
    int  kend;
    bit  in_req;
    kend        = (d < TO) ? d + AW + 2 : TO;
    start       = 1'b1;
    address_in  = a;
    data_in     = dt;
    write_en    = wr;
    slave_ready = 1'($urandom % 2);
    @(posedge clk); #1;
    for (int k = 0; k <= kend; k++) begin
      in_req      = (d < TO) ? (k <= d) : (k < TO);
      start       = (k < kend) ? ($urandom % 3 == 0) : 1'b0;
      address_in  = AW'($urandom);
      data_in     = DW'($urandom);
      write_en    = 1'($urandom % 2);
      slave_ready = (k == d) ? 1'b1 : (in_req ? 1'b0 : 1'($urandom % 2));
      if (k == abort_k) reset = 1'b1;
      @(negedge clk);
      check($sformatf("%s k=%0d", name, k), outs(), exp_outs(k, a, dt, wr, d));
      if (k == abort_k) begin
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check($sformatf("%s after_reset", name), outs(), 32'd0);
        return;
      end
      if (k < kend) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    start       = 1'b1;
    write_en    = 1'b1;
    address_in  = 12'hABC;
    data_in     = 8'h55;
    slave_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_with_start", outs(), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    idle_cycles(2, "post_reset");

    run_txn("wr_a5c", 12'hA5C, 8'h3B, 1'b1, 0, -1);
    idle_cycles(2, "gap1");
    run_txn("rd_fff", 12'hFFF, 8'hFF, 1'b0, 0, -1);
    idle_cycles(1, "gap2");
    run_txn("wait5", 12'h3C7, 8'hA6, 1'b1, 5, -1);
    idle_cycles(1, "gap3");
    run_txn("timeout", 12'h5A5, 8'hC3, 1'b1, 40, -1);
    run_txn("tmo_edge", 12'h123, 8'h81, 1'b1, 15, -1);
    run_txn("b2b_a", 12'h0F0, 8'h0F, 1'b1, 0, -1);
    run_txn("b2b_b", 12'h801, 8'h80, 1'b1, 0, -1);
    idle_cycles(1, "gap4");
    run_txn("abort", 12'h6DB, 8'h5D, 1'b1, 0, 7);
    idle_cycles(15, "post_abort");
    run_txn("after_abort", 12'h9E1, 8'h47, 1'b1, 2, -1);

    for (int t = 0; t < 40; t++) begin
      int d;
      d = ($urandom % 4 == 0) ? int'($urandom_range(14, 24)) : int'($urandom_range(0, 8));
      run_txn($sformatf("rnd%0d", t), AW'($urandom), DW'($urandom), 1'($urandom % 2), d, -1);
      if ($urandom % 2 == 1) idle_cycles(int'($urandom_range(1, 3)), $sformatf("rgap%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/master_out_port.md
Name: master_out_port

Overview:
- Master-side serialiser that drives the slave input port over the serial bus.
- Accepts a parallel transfer request (12-bit address, 8-bit data, read/write) from the master core.
- Performs the master_valid/slave_ready handshake, then shifts address and data out LSB-first on two parallel serial lines.
- Reports completion with a `done` pulse, or failure with a `timeout_err` pulse.

Parameters:
- ADDR_WIDTH, 12, number of address bits serialised.
- DATA_WIDTH, 8, number of data bits serialised; must be <= ADDR_WIDTH.
- TIMEOUT, 16, cycles to wait for slave_ready before aborting; 0 = wait forever.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  transfer request; sampled only in IDLE.
- write_en  in  1  1 = write (data sent), 0 = read (address only); latched with start.
- address_in  in  ADDR_WIDTH  target address; latched with start.
- data_in  in  DATA_WIDTH  write data; latched with start.
- slave_ready  in  1  slave idle/ready indication.
- master_valid  out  1  request to slave; handshake = master_valid & slave_ready.
- tx_address  out  1  serial address bit, LSB first.
- tx_data  out  1  serial data bit, LSB first.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse after the last address bit.
- timeout_err  out  1  one-cycle pulse when the handshake times out.

Behaviour:
- Reset is synchronous and active-high.
  - All outputs are 0 and the FSM is in IDLE.
  - The shift registers, bit counter and timeout counter are cleared.
  - Reset mid-transfer aborts immediately: no done, no error pulse.
- States and transitions: IDLE, REQ, SHIFT, DONE.
- IDLE
  - busy=0, master_valid=0, tx lines 0.
  - On start=1 at edge E0: latch address_in, data_in and write_en; go to REQ.
  - Requests arriving while not in IDLE are ignored (not queued).
- REQ
  - master_valid=1, busy=1, tx lines 0.
  - Timeout counter increments each cycle.
  - Edge where slave_ready=1 is the handshake edge Eh:
    - go to SHIFT and drop master_valid;
    - tx_address = addr[0];
    - tx_data = data[0] if write, else 0;
    - bit_cnt = 0.
  - If TIMEOUT>0 and the counter reaches TIMEOUT without slave_ready:
    - drop master_valid, pulse timeout_err for 1 cycle, return to IDLE;
    - the latched request is discarded.
- SHIFT
  - Bit i is stable on tx_address during the cycle between Eh+i and Eh+i+1, for i = 0..ADDR_WIDTH-1.
  - tx_data carries data bit i for i < DATA_WIDTH (writes only); otherwise 0.
  - The slave captures bit i at edge Eh+i+1.
  - After bit ADDR_WIDTH-1 has been held one cycle, i.e. at edge Eh+ADDR_WIDTH, go to DONE.
  - tx lines return to 0 at that edge.
- DONE
  - done=1 and busy=1 for exactly one cycle, then IDLE.
  - start is not sampled in DONE.
  - Minimum gap between the done pulse and the next master_valid is 1 cycle, which lets the slave return to idle.
- Latency
  - start to first master_valid: 1 cycle.
  - Handshake edge to done pulse: ADDR_WIDTH cycles (12 by default).
  - Total with immediate ready: 14 cycles from start edge to done falling.
- Inputs:
  - slave_ready is ignored outside REQ.
  - address_in, data_in and write_en changing after latch have no effect.
- Simultaneous events:
  - slave_ready high at the same edge the timeout would expire: handshake wins, no error.
  - reset together with start: reset wins.
- Timeout counter:
  - width ceil(log2(TIMEOUT+1)) minimum;
  - saturates, no wrap;
  - cleared on entry to REQ.

Test Plan:
- Write, address 0xA5C, data 0x3B, slave_ready tied 1:
  - master_valid high exactly 1 cycle;
  - tx_address sequence over 12 cycles is 0,0,1,1,1,0,1,0,0,1,0,1;
  - tx_data is 1,1,0,1,1,1,0,0 then 0;
  - done pulses 12 cycles after the handshake edge.
- Read, address 0xFFF, data_in 0xFF:
  - tx_address is all 1s for 12 cycles;
  - tx_data stays 0 throughout;
  - done pulses once.
- slave_ready held low 5 cycles then high (TIMEOUT=16):
  - master_valid stays high 6 cycles;
  - serialisation starts the cycle after the ready edge;
  - no timeout_err.
- slave_ready never high, TIMEOUT=16:
  - master_valid drops after 16 REQ cycles;
  - timeout_err pulses 1 cycle, busy falls;
  - tx lines never toggle.
- start asserted again mid-SHIFT with a different address:
  - ignored, and the current transfer completes unchanged.
- Back-to-back:
  - start held high: second transfer's master_valid rises 2 cycles after done.
- Reset asserted at bit 6:
  - next cycle all outputs 0 and no done;
  - a new start afterwards completes normally.
